// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: custom-0 ADD / MADD / NOP with an in-order result buffer.
// The optional EXC op (funct3=011) is compiled only when CVXIF_COPRO_EXC_EN is defined.

package cvxif_pkg;
  localparam int XLEN       = 32;
  localparam int X_ID_WIDTH = 4;
  localparam int X_NUM_RS   = 2;

  typedef struct packed {
    logic [31:0]                     instr;
    logic [1:0]                      mode;
    logic [X_ID_WIDTH-1:0]           id;
    logic [X_NUM_RS-1:0][XLEN-1:0]   rs;
    logic [X_NUM_RS-1:0]             rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       addr;
    logic [1:0]            mode;
    logic                  we;
    logic [1:0]            size;
    logic [XLEN-1:0]       wdata;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

  typedef struct packed {
    logic         x_issue_valid;
    x_issue_req_t x_issue_req;
    logic         x_commit_valid;
    x_commit_t    x_commit;
    logic         x_mem_ready;
    x_mem_resp_t  x_mem_resp;
    logic         x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_mem_valid;
    x_mem_req_t    x_mem_req;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;
endpackage

module cvxif_copro_responder
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  cvxif_pkg::cvxif_req_t  cvxif_req_i,
  output cvxif_pkg::cvxif_resp_t cvxif_resp_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MC_LATENCY);
  localparam logic [6:0] OPC_CUSTOM0     = 7'b0001011;
  localparam logic [5:0] EXCCODE_ILLEGAL = 6'd2;

  typedef enum logic {IDLE, BUSY} state_e;

  x_issue_req_t          ireq;
  logic [2:0]            funct3;
  logic                  op_legal, op_mc, res_we, res_exc, accept;
  logic [XLEN-1:0]       res_data;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [X_ID_WIDTH-1:0] busy_id_q;
  logic [XLEN-1:0]       busy_a_q, busy_b_q;
  logic                  mc_push;

  logic [PW:0]           count_q, count_d, wr_idx;
  x_result_t             fifo_q [DEPTH];
  x_result_t             fifo_d [DEPTH];
  x_result_t             push_entry;
  logic                  issue_ready, issue_fire, push, pop, head_valid;
  logic                  kill, busy_kill;
  logic [X_ID_WIDTH-1:0] kill_id;

  assign ireq   = cvxif_req_i.x_issue_req;
  assign funct3 = ireq.instr[14:12];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    op_legal = 1'b0;
    op_mc    = 1'b0;
    res_we   = 1'b0;
    res_exc  = 1'b0;
    res_data = '0;
    if (ireq.instr[6:0] == OPC_CUSTOM0 && ireq.instr[31:25] == 7'd0) begin
      case (funct3)
        3'b000: begin
          op_legal = (ireq.rs_valid == 2'b11);
          res_we   = 1'b1;
          res_data = ireq.rs[0] + ireq.rs[1];
        end
        3'b001: begin
          op_legal = (ireq.rs_valid == 2'b11);
          op_mc    = 1'b1;
          res_we   = 1'b1;
        end
        3'b010: op_legal = 1'b1;
`ifdef CVXIF_COPRO_EXC_EN
        3'b011: begin
          op_legal = 1'b1;
          res_exc  = 1'b1;
        end
`endif
        default: op_legal = 1'b0;
      endcase
    end
    accept = op_legal;
  end

  assign issue_ready = rst_ni && (state_q == IDLE) && (count_q < (PW+1)'(DEPTH));
  assign issue_fire  = cvxif_req_i.x_issue_valid && issue_ready && accept;

  assign kill      = cvxif_req_i.x_commit_valid && cvxif_req_i.x_commit.x_commit_kill;
  assign kill_id   = cvxif_req_i.x_commit.id;
  assign busy_kill = kill && (state_q == BUSY) && (kill_id == busy_id_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_push = 1'b0;
    case (state_q)
      IDLE: if (issue_fire && op_mc) begin
        state_d = BUSY;
        cnt_d   = CW'(MC_LATENCY - 1);
      end
      BUSY: begin
        if (busy_kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          mc_push = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // Operand latches only matter while BUSY, which reset already clears.
  always_ff @(posedge clk_i) begin
    if (issue_fire && op_mc) begin
      busy_id_q <= ireq.id;
      busy_a_q  <= ireq.rs[0];
      busy_b_q  <= ireq.rs[1];
    end
  end

  always_comb begin
    if (mc_push) begin
      push_entry = '{id: busy_id_q, data: busy_a_q + busy_b_q + busy_a_q,
                     we: 1'b1, exc: 1'b0, exccode: 6'd0};
    end else begin
      push_entry = '{id: ireq.id, data: res_data, we: res_we, exc: res_exc,
                     exccode: res_exc ? EXCCODE_ILLEGAL : 6'd0};
    end
  end

  assign push       = mc_push || (issue_fire && !op_mc);
  assign head_valid = (count_q != '0);
  assign pop        = head_valid && cvxif_req_i.x_result_ready;

  // Compacting buffer: slot 0 is the head; pops and kills close the gap in issue order.
  always_comb begin
    fifo_d = fifo_q;
    wr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count_q) && !(pop && i == 0) &&
          !(kill && fifo_q[i].id == kill_id)) begin
        fifo_d[wr_idx[PW-1:0]] = fifo_q[i];
        wr_idx                 = wr_idx + (PW+1)'(1);
      end
    end
    if (push) fifo_d[wr_idx[PW-1:0]] = push_entry;
    count_d = wr_idx + (PW+1)'(push);
  end

  // NOTE: buffer storage is not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  always_comb begin
    cvxif_resp_o                        = '0;
    cvxif_resp_o.x_issue_ready          = issue_ready;
    cvxif_resp_o.x_issue_resp.accept    = rst_ni && accept;
    cvxif_resp_o.x_issue_resp.writeback = rst_ni && accept && res_we;
    cvxif_resp_o.x_issue_resp.exc       = rst_ni && accept && res_exc;
    cvxif_resp_o.x_result_valid         = head_valid;
    if (head_valid) cvxif_resp_o.x_result = fifo_q[0];
  end

  logic unused_ok;
  assign unused_ok = ^{ireq.mode, ireq.instr[24:15], ireq.instr[11:7],
                       cvxif_req_i.x_mem_ready, cvxif_req_i.x_mem_resp};

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: directed steps then random traffic,
// compared every cycle against a queue-based model of the result stream.
module tb_cvxif_copro_responder;
  import cvxif_pkg::*;

  localparam int DEPTH      = 4;
  localparam int MC_LATENCY = 4;

  logic        clk;
  logic        rst_ni;
  cvxif_req_t  req;
  cvxif_resp_t resp;

  int checks   = 0;
  int failures = 0;

  x_result_t   q[$];
  bit          pend;
  int          pend_cnt;
  x_result_t   pend_res;
  bit          last_fire;
  logic [3:0]  next_id;

  cvxif_copro_responder #(.DEPTH(DEPTH), .MC_LATENCY(MC_LATENCY)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cvxif_req_i (req),
    .cvxif_resp_o(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_issue(input logic [2:0] f3, input logic [3:0] id,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rsv = 2'b11, input logic [6:0] opc = 7'h0B,
                           input logic [6:0] f7 = 7'h00);
    req.x_issue_valid          = 1'b1;
    req.x_issue_req.instr      = {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    req.x_issue_req.mode       = 2'b00;
    req.x_issue_req.id         = id;
    req.x_issue_req.rs[0]      = a;
    req.x_issue_req.rs[1]      = b;
    req.x_issue_req.rs_valid   = rsv;
  endtask

  task automatic no_issue();
    req.x_issue_valid = 1'b0;
    req.x_issue_req   = '0;
  endtask

  task automatic set_commit(input logic kill, input logic [3:0] id);
    req.x_commit_valid         = 1'b1;
    req.x_commit.x_commit_kill = kill;
    req.x_commit.id            = id;
  endtask

  // Acceptance rules of the custom-0 instruction set.
  function automatic bit legal_op(input x_issue_req_t r);
    if (r.instr[6:0] != 7'h0B || r.instr[31:25] != 7'd0) return 1'b0;
    case (r.instr[14:12])
      3'd0, 3'd1: return r.rs_valid == 2'b11;
      3'd2:       return 1'b1;
`ifdef CVXIF_COPRO_EXC_EN
      3'd3:       return 1'b1;
`endif
      default:    return 1'b0;
    endcase
  endfunction

  function automatic x_result_t expect_result(input x_issue_req_t r);
    x_result_t e;
    e    = '0;
    e.id = r.id;
    case (r.instr[14:12])
      3'd0: begin e.data = r.rs[0] + r.rs[1]; e.we = 1'b1; end
      3'd1: begin e.data = 2 * r.rs[0] + r.rs[1]; e.we = 1'b1; end
      3'd3: begin e.exc = 1'b1; e.exccode = 6'd2; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: inputs already applied after the previous edge; check, then model the edge.
  task automatic cycle();
    bit exp_ready, legal, mc;
    #1;
    exp_ready = !pend && (q.size() < DEPTH);
    legal     = legal_op(req.x_issue_req);
    mc        = (req.x_issue_req.instr[14:12] == 3'd1);
    check("issue_ready", resp.x_issue_ready, exp_ready);
    check("result_valid", resp.x_result_valid, q.size() != 0);
    if (q.size() != 0) check("result", resp.x_result, q[0]);
    else               check("result_idle", resp.x_result, '0);
    if (req.x_issue_valid && exp_ready) begin
      check("accept", resp.x_issue_resp.accept, legal);
      check("writeback", resp.x_issue_resp.writeback, legal && expect_result(req.x_issue_req).we);
    end
    if (q.size() != 0 && req.x_result_ready) void'(q.pop_front());
    if (req.x_commit_valid && req.x_commit.x_commit_kill) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].id == req.x_commit.id) q.delete(i);
      if (pend && pend_res.id == req.x_commit.id) pend = 1'b0;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        q.push_back(pend_res);
        pend = 1'b0;
      end
    end
    last_fire = req.x_issue_valid && exp_ready && legal;
    if (last_fire) begin
      if (mc) begin
        pend     = 1'b1;
        pend_cnt = MC_LATENCY;
        pend_res = expect_result(req.x_issue_req);
      end else begin
        q.push_back(expect_result(req.x_issue_req));
      end
    end
    @(posedge clk);
    #1;
    req.x_commit_valid = 1'b0;
  endtask

  initial begin
    req    = '0;
    rst_ni = 1'b0;
    pend   = 1'b0;
    next_id = '0;
    set_issue(3'd0, 4'd3, 32'd5, 32'd7);
    #2;
    check("rst_issue_ready", resp.x_issue_ready, 1'b0);
    check("rst_accept", resp.x_issue_resp.accept, 1'b0);
    check("rst_writeback", resp.x_issue_resp.writeback, 1'b0);
    check("rst_result_valid", resp.x_result_valid, 1'b0);
    check("rst_result", resp.x_result, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni             = 1'b1;
    req.x_result_ready = 1'b1;

    // ADD id=3 5+7, then wrap-around ADD.
    cycle();
    check("add_valid", resp.x_result_valid, 1'b1);
    check("add_data", resp.x_result.data, 32'd12);
    check("add_id", resp.x_result.id, 4'd3);
    set_issue(3'd0, 4'd4, 32'hFFFF_FFFF, 32'd1);
    cycle();
    no_issue();
    check("add_wrap", resp.x_result.data, 32'd0);
    cycle();

    // MADD id=1 2,3 with an ADD waiting behind it.
    set_issue(3'd1, 4'd1, 32'd2, 32'd3);
    cycle();
    set_issue(3'd0, 4'd5, 32'd10, 32'd20);
    repeat (MC_LATENCY) cycle();
    #1;
    check("madd_data", resp.x_result.data, 32'd7);
    check("madd_id", resp.x_result.id, 4'd1);
    check("madd_ready_after", resp.x_issue_ready, 1'b1);
    cycle();
    no_issue();
    repeat (2) cycle();

    // Fill the buffer with the consumer stalled, then drain one at a time.
    req.x_result_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_issue(3'd0, 4'(8 + i), 32'(i * 3), 32'd100);
      cycle();
    end
    check("full_ready", resp.x_issue_ready, 1'b0);
    req.x_result_ready = 1'b1;
    repeat (DEPTH + 3) cycle();
    no_issue();

    // Rejected encodings, NOP, and funct3=011.
    set_issue(3'd0, 4'd6, 32'd1, 32'd1, 2'b11, 7'h33);  cycle();
    set_issue(3'd7, 4'd6, 32'd1, 32'd1);                cycle();
    set_issue(3'd0, 4'd6, 32'd1, 32'd1, 2'b11, 7'h0B, 7'h20); cycle();
    set_issue(3'd0, 4'd6, 32'd1, 32'd1, 2'b01);         cycle();
    set_issue(3'd2, 4'd7, 32'd9, 32'd9);                cycle();
    set_issue(3'd3, 4'd2, 32'd9, 32'd9);                cycle();
    no_issue();
    repeat (2) cycle();

    // Kill a buffered entry; a kill=0 commit changes nothing; kill an in-flight MADD.
    req.x_result_ready = 1'b0;
    set_issue(3'd0, 4'd1, 32'd1, 32'd1); cycle();
    set_issue(3'd0, 4'd2, 32'd2, 32'd2); cycle();
    set_issue(3'd0, 4'd3, 32'd3, 32'd3); cycle();
    no_issue();
    set_commit(1'b1, 4'd2); cycle();
    set_commit(1'b0, 4'd3); cycle();
    req.x_result_ready = 1'b1;
    repeat (3) cycle();
    set_issue(3'd1, 4'd6, 32'd4, 32'd4); cycle();
    no_issue();
    cycle();
    set_commit(1'b1, 4'd6); cycle();
    repeat (MC_LATENCY + 1) cycle();

    // Reset while BUSY with two buffered results.
    req.x_result_ready = 1'b0;
    set_issue(3'd0, 4'd1, 32'd1, 32'd2); cycle();
    set_issue(3'd0, 4'd2, 32'd3, 32'd4); cycle();
    set_issue(3'd1, 4'd3, 32'd5, 32'd6); cycle();
    no_issue();
    cycle();
    rst_ni = 1'b0;
    #1;
    check("midrst_result_valid", resp.x_result_valid, 1'b0);
    check("midrst_issue_ready", resp.x_issue_ready, 1'b0);
    check("midrst_result", resp.x_result, '0);
    q.delete();
    pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni             = 1'b1;
    req.x_result_ready = 1'b1;
    repeat (MC_LATENCY + 3) cycle();

    // Random traffic with occasional kills; live ids stay unique.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] f3;
      logic [1:0] rsv;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f3 = 3'd0;
        4, 5:       f3 = 3'd1;
        6:          f3 = 3'd2;
        7:          f3 = 3'd3;
        default:    f3 = 3'd7;
      endcase
      rsv = (f3 <= 3'd1 && $urandom_range(0, 7) == 0) ? 2'(($urandom_range(0, 2))) : 2'b11;
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 15) == 0)
          set_issue(f3, next_id, $urandom, $urandom, rsv, 7'h33);
        else
          set_issue(f3, next_id, $urandom, $urandom, rsv);
      end else begin
        no_issue();
      end
      req.x_result_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 11) == 0)
        set_commit($urandom_range(0, 1) == 1, next_id - 4'(1 + $urandom_range(0, 4)));
      cycle();
      if (last_fire) next_id = next_id + 4'd1;
    end
    no_issue();
    req.x_result_ready = 1'b1;
    repeat (MC_LATENCY + DEPTH + 2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cvxif_copro_responder.md
CVXIF_COPRO_RESPONDER -- requirements
Module: cvxif_copro_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter MC_LATENCY, default 4, cycles from accept to result push for multi-cycle op (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cvxif_req_i  input  cvxif_pkg::cvxif_req_t  issue/commit/result-ready from core.
REQ-006 SHALL have port cvxif_resp_o  output  cvxif_pkg::cvxif_resp_t  issue-ready/accept/result to core.

Function
REQ-007 SHALL decode x_issue_req.instr: opcode 7'b0001011 (custom-0) required, funct3 selects op, funct7 must be 0.
REQ-008 SHALL support funct3=000 ADD: data=rs[0]+rs[1], XLEN wrap-around, we=1, single-cycle.
REQ-009 SHALL support funct3=001 MADD: data=rs[0]+rs[1]+rs[0], wrap-around, we=1, multi-cycle.
REQ-010 SHALL support funct3=010 NOP: data=0, we=0, single-cycle.
REQ-011 SHALL reject any other encoding, or any op whose needed rs_valid bits [1:0] are not both set: accept=0, writeback=0, nothing enqueued.
REQ-012 SHALL drive x_issue_ready=1 only in state IDLE with buffer occupancy < DEPTH; full with same-cycle pop still gives ready=0.
REQ-013 SHALL drive x_issue_resp.accept and writeback combinationally from the current request; they are meaningful only when x_issue_valid && x_issue_ready.
REQ-014 SHALL treat an issue handshake as x_issue_valid && x_issue_ready; accepted single-cycle ops push {id,data,we,exc=0,exccode=0} same edge, visible on x_result next cycle.
REQ-015 SHALL use FSM IDLE->BUSY on accepted MADD (latch id, operands); BUSY down-counts from MC_LATENCY-1; at 0 push result, return to IDLE same edge.
REQ-016 SHALL hold x_issue_ready=0 in BUSY; entry reserved at MADD accept, so BUSY push never overflows.
REQ-017 SHALL present buffer head on x_result with x_result_valid=!empty; pop on x_result_valid && x_result_ready; order = issue order.
REQ-018 SHALL allow push and pop in the same cycle (occupancy unchanged); pointers wrap modulo DEPTH.
REQ-019 SHALL on cvxif_req_i.x_commit_valid with x_commit_kill=1 and id matching a buffered or BUSY instruction, drop that entry/cancel BUSY (to IDLE, no push); kill=0 commits are ignored.
REQ-020 SHALL drive unused response fields (mem/register interfaces) to 0.

Reset
REQ-021 SHALL on rst_ni low asynchronously clear: FSM=IDLE, counter=0, buffer empty, pointers=0.
REQ-022 SHALL hold outputs during reset: x_issue_ready=0, accept=0, writeback=0, x_result_valid=0, x_result='0.
REQ-023 SHALL discard in-flight BUSY op and all buffered results on reset mid-operation; x_issue_ready returns to 1 on the first cycle after release.

Configuration
REQ-024 SHALL compile funct3=011 EXC op only when CVXIF_COPRO_EXC_EN is defined.
REQ-025 With CVXIF_COPRO_EXC_EN: EXC accepted single-cycle, result exc=1, exccode=2 (illegal instruction), we=0, data=0.
REQ-026 Without CVXIF_COPRO_EXC_EN: funct3=011 rejected per REQ-011; exc output tied 0.

Verification
REQ-027 Reset then ADD id=3 rs0=5 rs1=7 -> accept=1, next cycle x_result_valid=1 id=3 data=12 we=1.
REQ-028 ADD rs0=XLEN-max rs1=1 -> data=0 (wrap).
REQ-029 MADD id=1 rs0=2 rs1=3, MC_LATENCY=4 -> ready=0 for 4 cycles, result data=7 id=1; ADD issued during BUSY stalls until IDLE.
REQ-030 Hold x_result_ready=0, issue 4 ADDs (DEPTH=4) -> ready=0 after 4th; one pop -> ready=1; results drained in issue order.
REQ-031 Opcode 0x33 or funct3=111 -> accept=0, writeback=0, no result; funct3=011 -> exc=1 exccode=2 with macro, rejected without.
REQ-032 Assert rst_ni low during BUSY with 2 buffered results -> x_result_valid=0 immediately, no stale results after release.
